// File: rtl/serial_a_paralelo.sv
// Serial-to-parallel lane deserializer. Finds byte alignment on the COM symbol,
// locks after COM_COUNT aligned COMs, then emits each recovered byte MSB-first.
module serial_a_paralelo #(
    parameter logic [7:0]  COM_SYMBOL = 8'hBC,
    parameter int unsigned COM_COUNT  = 4
) (
    input  logic       clk32f,
    input  logic       reset,
    input  logic       in,
    output logic [7:0] out,
    output logic       out_valid,
    output logic       byte_strobe,
    output logic       active
);

    typedef enum logic [1:0] {
        StSearch,
        StCount,
        StActive
    } state_t;

    localparam logic [3:0] ComCountW = 4'(COM_COUNT);

    state_t     state_q, state_d;
    // Only the low 7 bits of the previous window survive into the next one.
    logic [6:0] sr_q, sr_d;
    logic [2:0] bc_q, bc_d;
    logic [3:0] com_cnt_q, com_cnt_d;
    logic [7:0] out_q, out_d;
    logic       out_valid_q, out_valid_d;
    logic       byte_strobe_q, byte_strobe_d;

    logic [7:0] nsr;
    logic       nsr_is_com;
    logic       boundary;

    assign nsr        = {sr_q, in};
    assign nsr_is_com = (nsr == COM_SYMBOL);
    assign boundary   = (bc_q == 3'd7);

    always_comb begin
        state_d       = state_q;
        sr_d          = nsr[6:0];
        bc_d          = bc_q + 3'd1;
        com_cnt_d     = com_cnt_q;
        out_d         = out_q;
        out_valid_d   = out_valid_q;
        byte_strobe_d = 1'b0;

        unique case (state_q)
            StSearch: begin
                // Bit-granular search; any match restarts alignment from here.
                bc_d = 3'd0;
                if (nsr_is_com) begin
                    com_cnt_d = 4'd1;
                    state_d   = (ComCountW == 4'd1) ? StActive : StCount;
                end
            end
            StCount: begin
                if (boundary) begin
                    if (nsr_is_com) begin
                        com_cnt_d = com_cnt_q + 4'd1;
                        if (com_cnt_q + 4'd1 == ComCountW) begin
                            state_d = StActive;
                        end
                    end else begin
                        com_cnt_d = 4'd0;
                        state_d   = StSearch;
                    end
                end
            end
            StActive: begin
                if (boundary) begin
                    out_d         = nsr;
                    out_valid_d   = !nsr_is_com;
                    byte_strobe_d = 1'b1;
                end
            end
            default: begin
                state_d = StSearch;
            end
        endcase
    end

    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            state_q       <= StSearch;
            sr_q          <= 7'd0;
            bc_q          <= 3'd0;
            com_cnt_q     <= 4'd0;
            out_q         <= 8'h00;
            out_valid_q   <= 1'b0;
            byte_strobe_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            bc_q          <= bc_d;
            com_cnt_q     <= com_cnt_d;
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            byte_strobe_q <= byte_strobe_d;
        end
    end

    assign out         = out_q;
    assign out_valid   = out_valid_q;
    assign byte_strobe = byte_strobe_q;
    assign active      = (state_q == StActive);

endmodule

// File: tb/tb_serial_a_paralelo.sv
// Bench for serial_a_paralelo: directed and random bit streams checked edge by edge
// against a stream-scanning model of alignment, lock and byte recovery.
module tb_serial_a_paralelo;

    localparam logic [7:0] COM = 8'hBC;
    localparam int         CC  = 4;

    logic       clk32f = 1'b0;
    logic       reset;
    logic       in;
    logic [7:0] out;
    logic       out_valid;
    logic       byte_strobe;
    logic       active;

    int         n_cmp = 0;
    int         n_err = 0;
    bit         stim[$];
    logic [7:0] got[$];

    always #5 clk32f = ~clk32f;

    serial_a_paralelo #(
        .COM_SYMBOL(COM),
        .COM_COUNT (CC)
    ) dut (
        .clk32f     (clk32f),
        .reset      (reset),
        .in         (in),
        .out        (out),
        .out_valid  (out_valid),
        .byte_strobe(byte_strobe),
        .active     (active)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_out"}, out, 8'h00);
        chk({tag, "_valid"}, {7'd0, out_valid}, 8'h00);
        chk({tag, "_strobe"}, {7'd0, byte_strobe}, 8'h00);
        chk({tag, "_active"}, {7'd0, active}, 8'h00);
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) stim.push_back(b[i]);
    endtask

    // Byte formed by the 8 bits ending at edge e (1-based); bits before reset read as 0.
    function automatic logic [7:0] win(input int e);
        logic [7:0] w = 8'h00;
        for (int j = e - 7; j <= e; j++) w = {w[6:0], (j >= 1) ? stim[j-1] : 1'b0};
        return w;
    endfunction

    // Edge at which the lane locks, or 0 if it never does within the stream.
    function automatic int find_lock();
        int n = stim.size();
        int p = 1;
        while (p <= n) begin
            int e = p;
            bit ok = 1'b1;
            while (e <= n && win(e) != COM) e++;
            if (e > n) return 0;
            for (int k = 1; k < CC; k++) begin
                if (e + 8 * k > n) return 0;
                if (win(e + 8 * k) != COM) begin
                    p  = e + 8 * k + 1;
                    ok = 1'b0;
                    break;
                end
            end
            if (ok) return e + 8 * (CC - 1);
        end
        return 0;
    endfunction

    task automatic run_segment(input int rst_at, input bit collect);
        int         lock;
        logic [7:0] eo;
        logic       ev, es, ea;
        reset = 1'b0;
        in    = 1'b0;
        @(posedge clk32f);
        #1;
        check_zero("reset");
        reset = 1'b1;
        lock  = find_lock();
        for (int t = 1; t <= stim.size(); t++) begin
            in = stim[t-1];
            @(posedge clk32f);
            #1;
            ea = (lock > 0) && (t >= lock);
            eo = 8'h00;
            ev = 1'b0;
            es = 1'b0;
            if (ea && t >= lock + 8) begin
                int b = lock + ((t - lock) / 8) * 8;
                eo = win(b);
                ev = (eo != COM);
                es = (t == b);
            end
            chk("out", out, eo);
            chk("out_valid", {7'd0, out_valid}, {7'd0, ev});
            chk("byte_strobe", {7'd0, byte_strobe}, {7'd0, es});
            chk("active", {7'd0, active}, {7'd0, ea});
            if (collect && byte_strobe && out_valid) got.push_back(out);
            if (t == rst_at) begin
                reset = 1'b0;
                #1;
                check_zero("async_rst");
                repeat (2) @(posedge clk32f);
                #1;
                check_zero("rst_hold");
                break;
            end
        end
        stim.delete();
    endtask

    initial begin
        reset = 1'b0;
        in    = 1'b0;
        repeat (2) @(posedge clk32f);
        #1;
        check_zero("por");

        // Aligned lock, then data, then an idle COM.
        repeat (4) push_byte(COM);
        push_byte(8'h3A);
        push_byte(8'h5C);
        push_byte(COM);
        push_byte(8'($urandom));
        run_segment(0, 1'b0);

        // Three-bit offset before the COMs.
        stim.push_back(1'b1);
        stim.push_back(1'b0);
        stim.push_back(1'b1);
        repeat (4) push_byte(COM);
        push_byte(8'hA5);
        push_byte(8'($urandom));
        run_segment(0, 1'b0);

        // Broken COM run must fall back to search.
        push_byte(COM);
        push_byte(COM);
        push_byte(8'h55);
        repeat (4) push_byte(COM);
        push_byte(8'h12);
        run_segment(0, 1'b0);

        // Reset mid-byte while active, then a fresh lock is required.
        repeat (4) push_byte(COM);
        repeat (4) push_byte(8'($urandom));
        run_segment(32 + 16 + 3, 1'b0);
        repeat (3) push_byte(COM);
        push_byte(8'h77);
        push_byte(8'h66);
        repeat (4) push_byte(COM);
        push_byte(8'h99);
        run_segment(0, 1'b0);

        // Serializer loop-back: idle slots sent as COM between valid bytes.
        got.delete();
        repeat (4) push_byte(COM);
        for (int i = 1; i <= 32; i++) begin
            push_byte(8'(i));
            push_byte(COM);
        end
        run_segment(0, 1'b1);
        chk("lb_count", 8'(got.size()), 8'd32);
        for (int i = 0; i < got.size() && i < 32; i++) chk("lb_byte", got[i], 8'(i + 1));

        // Random streams: garbage prefix, variable COM run, mixed data.
        for (int s = 0; s < 8; s++) begin
            int np = $urandom_range(0, 7);
            int nc = $urandom_range(2, 5);
            int nb = $urandom_range(8, 14);
            for (int i = 0; i < np; i++) stim.push_back(1'($urandom));
            repeat (nc) push_byte(COM);
            for (int i = 0; i < nb; i++) push_byte(($urandom_range(0, 3) == 0) ? COM : 8'($urandom));
            run_segment(0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_a_paralelo.md
Name: serial_a_paralelo

Overview:
Deserializer stage that sits directly downstream of the 8-bit parallel-to-serial lane serializer. Shifts in a 1-bit, MSB-first serial stream on clk32f and finds byte alignment by searching for the COM symbol (0xBC). It declares the lane active after COM_COUNT consecutive aligned COMs, then emits recovered bytes. COM bytes in the active state count as idle and are not flagged valid.

Parameters:
COM_SYMBOL, 8'hBC, alignment/idle symbol
COM_COUNT, 4, consecutive aligned COMs required before ACTIVE; legal range 1..15

Ports:
clk32f  input  1  bit clock; one serial bit sampled per rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in  input  1  serial data, MSB of each byte first
out  output  8  recovered byte, held between byte boundaries
out_valid  output  1  out holds a non-COM data byte; held with out
byte_strobe  output  1  one-cycle pulse on each byte boundary while ACTIVE
active  output  1  lane aligned and locked

Behaviour:
- Reset (reset=0, asynchronous): sr=0, bc=0, com_cnt=0, state=SEARCH, out=8'h00, out_valid=0, byte_strobe=0, active=0. Effect is immediate, including mid-byte and in any state.
- Shift register: every edge out of reset, sr <= nsr, where nsr = {sr[6:0], in}. All compare and capture logic below uses nsr, so the byte completes on the edge that samples its 8th bit.
- bc (3-bit): counts bits within the current byte. A boundary is the edge where bc==7. bc wraps 7->0.
- State encoding: SEARCH, COUNT, ACTIVE (2 bits).
- SEARCH: compare nsr against COM_SYMBOL on every edge (bit-granular search).
  - On a match, set bc <= 0 and com_cnt <= 1.
  - Next state is ACTIVE if COM_COUNT==1, else COUNT.
  - bc is held at 0 while in SEARCH.
- COUNT: bc increments every edge. At each boundary:
  - nsr==COM_SYMBOL: com_cnt++. When the new count equals COM_COUNT, go to ACTIVE.
  - Otherwise: return to SEARCH with com_cnt <= 0. A false match from a bit-shifted pattern is rejected here.
- ACTIVE: bc increments every edge. At each boundary:
  - out <= nsr.
  - out_valid <= (nsr != COM_SYMBOL).
  - byte_strobe <= 1 for that cycle only.
  - out and out_valid hold for the following 8 cycles.
- active=1 exactly while state==ACTIVE. It rises on the edge that completes the COM_COUNT-th COM.
- ACTIVE is left only by reset. No loss-of-lock detection in this block.
- Outside ACTIVE: out=0, out_valid=0, byte_strobe=0.
- Latency: the 8th bit sampled at edge N is visible on out, out_valid and byte_strobe after edge N (zero additional cycles).
- The entering edge into ACTIVE does not itself emit a byte. The first emitted byte completes 8 edges later.
- Simultaneous events: reset dominates everything. In SEARCH a match always restarts alignment, so there is no overlapping-match ambiguity.
- Widths: com_cnt is 4 bits. Compare com_cnt+1 against COM_COUNT in 4 bits; no overflow is possible within the legal range.

Test Plan:
1. Release reset, drive 4×0xBC MSB-first aligned from the first bit.
   - active rises on edge 32.
   - out_valid=0 and out=0 throughout.
2. After lock, drive 0x3A then 0x5C.
   - byte_strobe pulses at edges 40 and 48.
   - out=8'h3A with out_valid=1 for cycles 40–47, then out=8'h5C.
   - A following 0xBC sets out=8'hBC and out_valid=0.
3. Prefix 3 arbitrary bits (1,0,1), then 4×0xBC and 0xA5.
   - Alignment is found at bit offset 3; active rises on edge 35.
   - out=8'hA5 with out_valid=1 at edge 43.
4. Drive 0xBC, 0xBC, 0x55, then 4×0xBC.
   - FSM returns to SEARCH at the 0x55 boundary; active stays 0.
   - active rises only after the last 4 COMs complete.
5. In ACTIVE, assert reset mid-byte (bit 3) for 2 cycles.
   - out, out_valid, byte_strobe and active go to 0 immediately, without a clock.
   - After release, 4 fresh aligned COMs are required before data reappears.
6. Loop-back from the 8-bit serializer on a shared clk32f.
   - Serializer input alternates valid bytes 0x01..0x20 with invalid slots, which it sends as 0xBC.
   - After lock, every valid byte appears on out in order with out_valid=1.
   - Every idle slot gives out_valid=0.
   - No byte is dropped or duplicated.
